kamus_ex_sequencer: RTL and testbench
=====================================

// Module: kamus_ex_sequencer
// PURPOSE
//  Execute-stage controller between decode/register-read and writeback. Accepts one decoded
//  instruction per valid/ready handshake, registers it, and either drives the single-cycle
//  kamus_EX datapath or runs the iterative RV32M multiply/divide unit.
//  Presents one registered result per instruction to writeback and stalls upstream while busy.
// PARAMETERS
//  XLEN     32  operand/result width; only 32 is supported
//  ITER_CNT 32  iteration cycles for MUL*/DIV*/REM*; one result bit per cycle
// PORTS
//  clk_i         in   1     single clock; all state on rising edge
//  rst_i         in   1     synchronous, active-high reset
//  flush_i       in   1     kill in-flight instruction (branch/trap redirect)
//  in_valid_i    in   1     upstream presents instruction
//  in_ready_o    out  1     sequencer accepts this cycle
//  instr_i       in   instr_decoded_t  decoded instruction
//  rs1_value_i   in   32    rs1 operand
//  rs2_value_i   in   32    rs2 operand
//  ex_instr_o    out  instr_decoded_t  registered instruction to kamus_EX
//  ex_rs1_o      out  32    registered rs1 to kamus_EX
//  ex_rs2_o      out  32    registered rs2 to kamus_EX
//  ex_result_i   in   32    combinational ex_o returned by kamus_EX
//  out_valid_o   out  1     result valid for writeback
//  out_ready_i   in   1     writeback accepts result
//  out_instr_o   out  instr_decoded_t  instruction belonging to result_o
//  result_o      out  32    registered result
//  busy_o        out  1     iterative operation in progress
// BEHAVIOUR
//  Reset: state=IDLE; in_ready_o=1; out_valid_o=0; busy_o=0; result_o=0; ex_* operands=0.
//  Handshake: transfer when valid&&ready. in_ready_o = (IDLE) || (DONE && out_ready_i).
//  out_valid_o stays 1 with result_o/out_instr_o stable until out_ready_i; no drop, no dup.
//  FSM: IDLE -> ALU (non-M op accepted) | MULDIV (M op accepted).
//   ALU: capture ex_result_i into result_o, go DONE. Accepted cycle N -> out_valid_o at N+2.
//   MULDIV: busy_o=1; count 0..ITER_CNT-1; sign fix-up on final count; go DONE.
//   Accepted N -> out_valid_o at N+ITER_CNT+2 (N+34).
//   DONE: out_valid_o=1; on out_ready_i: new accept -> ALU/MULDIV, else IDLE.
//  Arithmetic: MUL low 32b; MULH s*s, MULHSU s*u, MULHU u*u, high 32b of 64b product.
//   DIV/REM truncate toward zero; REM sign follows dividend.
//  Div by zero: DIV/DIVU=32'hFFFF_FFFF; REM/REMU=rs1. Runs the full ITER_CNT; no early exit.
//  Overflow: DIV 32'h8000_0000 / -1 = 32'h8000_0000; REM = 0.
//  flush_i: highest priority except rst_i. Next state IDLE; out_valid_o=0; busy_o=0.
//   in_ready_o forced 0 in the flush cycle. Counter cleared.
//  rst_i mid-operation: identical to flush plus all registers to reset values.
//  Upstream stability: instr_i/operands sampled only on accept; may change otherwise.
// CONFIGURATION
//  KAMUS_M_EXT_EN defined: M ops use MULDIV as above; the iterative unit is instantiated.
//  Undefined: no iterative unit, busy_o tied 0, MULDIV state absent.
//   M ops take the ALU path and return ex_result_i, matching kamus_EX default.
// STRUCTURE
//  kamus_pkg gains:
//   M-op encodings MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU in the operation enum
//   ex_seq_state_e {IDLE,ALU,MULDIV,DONE}; MULDIV_ITER_CNT=32
//  Sub-module kamus_muldiv_iter: start/op/a/b in, done/result out.
//   Radix-2 shift-add multiplier and restoring divider on magnitudes; sign fix-up inside.
//   Present only under KAMUS_M_EXT_EN.
//  kamus_EX is instantiated by the parent, not inside this block.
// TESTING
//  1 ADD rs1=5,rs2=7 accepted cycle N, out_ready_i=1 -> out_valid_o at N+2, result_o=12.
//  2 Back-to-back ADD,XOR with out_ready_i=1 -> in_ready_o=1 in DONE; results in order.
//    No bubble on input.
//  3 DIV rs1=-7,rs2=2 -> busy_o for 33 cycles, out_valid_o at N+34, result_o=-3.
//    REM same operands -> -1.
//  4 DIVU x/0 -> 32'hFFFF_FFFF; REM 9/0 -> 9. DIV 32'h8000_0000/-1 -> 32'h8000_0000.
//  5 MULH 32'h8000_0000*32'h8000_0000 -> 32'h4000_0000.
//    MULHU 32'hFFFF_FFFF*2 -> 1; MUL -> 32'hFFFF_FFFE.
//  6 flush_i at iteration 10 of a DIV -> IDLE next cycle; no out_valid_o.
//    Then ADD 1+1 -> result_o=2.
//    Also: out_ready_i=0 for 5 cycles in DONE -> result_o held stable.

Source files
------------

// File: rtl/kamus_pkg.sv
// rtl/kamus_pkg.sv - shared kamus types: operations, decoded instruction, execute sequencer states
package kamus_pkg;

    localparam int XLEN            = 32;
    localparam int MULDIV_ITER_CNT = 32;

    typedef enum logic [4:0] {
        ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [4:0] rd;
    } instr_decoded_t;

    typedef enum logic [1:0] {IDLE, ALU, MULDIV, DONE} ex_seq_state_e;

    function automatic logic is_m_op(op_e op);
        return op inside {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic is_div_op(op_e op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/kamus_muldiv_iter.sv
// rtl/kamus_muldiv_iter.sv - iterative RV32M unit: radix-2 shift-add multiply, restoring divide
module kamus_muldiv_iter
    import kamus_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            kill_i,
    input  logic            start_i,
    input  op_e             op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    logic            run_q, fix_q, neg_q, rneg_q;
    logic [4:0]      cnt_q;
    op_e             op_q;
    logic [XLEN-1:0] hi_q, lo_q, addend_q;

    logic            a_signed, b_signed, sa, sb;
    logic [XLEN-1:0] ma, mb, hi_step, lo_step;
    logic [XLEN:0]   sum, shifted, diff;
    logic [63:0]     prod;

    // Signedness of each operand for the operation being started, and its magnitude
    always_comb begin
        a_signed = op_i inside {MUL, MULH, MULHSU, DIV, REM};
        b_signed = op_i inside {MUL, MULH, DIV, REM};
        sa       = a_signed & a_i[XLEN-1];
        sb       = b_signed & b_i[XLEN-1];
        ma       = sa ? (~a_i + 32'd1) : a_i;
        mb       = sb ? (~b_i + 32'd1) : b_i;
    end

    // One result bit per step; {hi,lo} is the product or the {remainder,quotient} pair
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, addend_q} : 33'd0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, addend_q};
        if (is_div_op(op_q)) begin
            hi_step = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], ~diff[XLEN]};
        end else begin
            hi_step = sum[XLEN:1];
            lo_step = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up applied to the magnitude result once all steps are done
    always_comb begin
        prod = neg_q ? (~{hi_q, lo_q} + 64'd1) : {hi_q, lo_q};
        case (op_q)
            MUL:                 result_o = prod[31:0];
            MULH, MULHSU, MULHU: result_o = prod[63:32];
            DIV, DIVU:           result_o = neg_q ? (~lo_q + 32'd1) : lo_q;
            default:             result_o = rneg_q ? (~hi_q + 32'd1) : hi_q;
        endcase
    end

    assign done_o = fix_q;

    // Operand load, iteration counter and step registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q    <= 1'b0;
            fix_q    <= 1'b0;
            cnt_q    <= 5'd0;
            op_q     <= ADD;
            hi_q     <= '0;
            lo_q     <= '0;
            addend_q <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
        end else if (kill_i) begin
            run_q <= 1'b0;
            fix_q <= 1'b0;
            cnt_q <= 5'd0;
        end else if (start_i) begin
            run_q    <= 1'b1;
            fix_q    <= 1'b0;
            cnt_q    <= 5'd0;
            op_q     <= op_i;
            hi_q     <= '0;
            lo_q     <= is_div_op(op_i) ? ma : mb;
            addend_q <= is_div_op(op_i) ? mb : ma;
            // a zero divisor yields an all-ones quotient that must stay unsigned
            neg_q    <= is_div_op(op_i) ? ((sa ^ sb) & (b_i != '0)) : (sa ^ sb);
            rneg_q   <= sa;
        end else if (run_q) begin
            hi_q  <= hi_step;
            lo_q  <= lo_step;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'(MULDIV_ITER_CNT - 1)) begin
                run_q <= 1'b0;
                fix_q <= 1'b1;
            end
        end else begin
            fix_q <= 1'b0;
        end
    end

endmodule

// File: rtl/kamus_ex_sequencer.sv
// rtl/kamus_ex_sequencer.sv - execute-stage sequencer; KAMUS_M_EXT_EN adds the iterative M unit
module kamus_ex_sequencer
    import kamus_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  instr_decoded_t  instr_i,
    input  logic [XLEN-1:0] rs1_value_i,
    input  logic [XLEN-1:0] rs2_value_i,
    output instr_decoded_t  ex_instr_o,
    output logic [XLEN-1:0] ex_rs1_o,
    output logic [XLEN-1:0] ex_rs2_o,
    input  logic [XLEN-1:0] ex_result_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output instr_decoded_t  out_instr_o,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    ex_seq_state_e   state_q, state_d, accept_state;
    instr_decoded_t  ex_instr_q;
    logic [XLEN-1:0] ex_rs1_q, ex_rs2_q, result_q, result_d;
    logic            accept;

    assign in_ready_o  = !flush_i && ((state_q == IDLE) || ((state_q == DONE) && out_ready_i));
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == DONE);
    assign ex_instr_o  = ex_instr_q;
    assign ex_rs1_o    = ex_rs1_q;
    assign ex_rs2_o    = ex_rs2_q;
    assign out_instr_o = ex_instr_q;
    assign result_o    = result_q;

`ifdef KAMUS_M_EXT_EN
    logic            md_done;
    logic [XLEN-1:0] md_result;

    kamus_muldiv_iter u_muldiv_iter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .kill_i   (flush_i),
        .start_i  (accept && is_m_op(instr_i.op)),
        .op_i     (instr_i.op),
        .a_i      (rs1_value_i),
        .b_i      (rs2_value_i),
        .done_o   (md_done),
        .result_o (md_result)
    );

    assign busy_o       = (state_q == MULDIV);
    assign accept_state = is_m_op(instr_i.op) ? MULDIV : ALU;
`else
    assign busy_o       = 1'b0;
    assign accept_state = ALU;
`endif

    // Next state and result capture; flush overrides everything but reset
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (accept) state_d = accept_state;
            ALU: begin
                result_d = ex_result_i;
                state_d  = DONE;
            end
`ifdef KAMUS_M_EXT_EN
            MULDIV: if (md_done) begin
                result_d = md_result;
                state_d  = DONE;
            end
`endif
            DONE: if (out_ready_i) state_d = accept ? accept_state : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    // State, result and the instruction/operands latched on accept
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            result_q   <= '0;
            ex_instr_q <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (accept) begin
                ex_instr_q <= instr_i;
                ex_rs1_q   <= rs1_value_i;
                ex_rs2_q   <= rs2_value_i;
            end
        end
    end

endmodule

// File: tb/tb_kamus_ex_sequencer.sv
// tb/tb_kamus_ex_sequencer.sv - randomized self-checking bench for kamus_ex_sequencer
module tb_kamus_ex_sequencer;
    import kamus_pkg::*;

`ifdef KAMUS_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic           in_ready, out_valid, busy;
    instr_decoded_t instr = '0, ex_instr, out_instr;
    logic [31:0]    rs1 = '0, rs2 = '0, ex_rs1, ex_rs2, ex_result, result;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
        int          acc;
        int          lat;
    } item_t;

    item_t q[$];
    int    total = 0, bad = 0, cyc = 0, busy_cnt = 0, ready_mode = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    kamus_ex_sequencer dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .instr_i(instr),
        .rs1_value_i(rs1), .rs2_value_i(rs2),
        .ex_instr_o(ex_instr), .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_result_i(ex_result),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_instr_o(out_instr),
        .result_o(result), .busy_o(busy)
    );

    // Stand-in for kamus_EX: single-cycle ALU, M ops return zero
    function automatic logic [31:0] ex_model(op_e op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        case (op)
            ADD:     r = a + b;
            SUB:     r = a - b;
            XOR:     r = a ^ b;
            OR:      r = a | b;
            AND:     r = a & b;
            SLL:     r = a << b[4:0];
            SRL:     r = a >> b[4:0];
            SRA:     r = $signed(a) >>> b[4:0];
            SLT:     r = {31'b0, $signed(a) < $signed(b)};
            SLTU:    r = {31'b0, a < b};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // RV32M reference from 64-bit arithmetic
    function automatic logic [31:0] m_ref(op_e op, logic [31:0] a, logic [31:0] b);
        longint      sa, sb, p;
        logic [63:0] u;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 0;
        u  = '0;
        r  = 32'h0;
        case (op)
            MUL:    begin p = sa * sb; r = p[31:0]; end
            MULH:   begin p = sa * sb; r = p[63:32]; end
            MULHSU: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
            MULHU:  begin u = {32'b0, a} * {32'b0, b}; r = u[63:32]; end
            DIV:    if (b == 0) r = '1; else begin p = sa / sb; r = p[31:0]; end
            DIVU:   r = (b == 0) ? '1 : a / b;
            REM:    if (b == 0) r = a; else begin p = sa % sb; r = p[31:0]; end
            REMU:   r = (b == 0) ? a : a % b;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] model(op_e op, logic [31:0] a, logic [31:0] b);
        return (M_EN && is_m_op(op)) ? m_ref(op, a, b) : ex_model(op, a, b);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    assign ex_result = ex_model(ex_instr.op, ex_rs1, ex_rs2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic send(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, output int acc);
        int         n;
        logic [4:0] rd;
        rd = 5'($urandom);
        @(negedge clk);
        in_valid = 1'b1;
        instr.op = op;
        instr.rd = rd;
        rs1      = a;
        rs2      = b;
        #1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        acc = -1;
        if (!in_ready) chk("accept_timeout", {31'b0, in_ready}, 32'd1);
        else begin
            acc = cyc;
            q.push_back('{rd: rd, res: exp, acc: cyc, lat: (M_EN && is_m_op(op)) ? 34 : 2});
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        instr.op = op_e'(5'($urandom_range(0, 17)));
        instr.rd = 5'($urandom);
        rs1      = $urandom;
        rs2      = $urandom;
    endtask

    task automatic drain();
        int n;
        idle();
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    // Writeback side: drives out_ready and scores every presented result
    initial begin
        bit presenting;
        presenting = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom % 2);
                default: out_ready = 1'b0;
            endcase
            #1;
            if (busy) busy_cnt++;
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_valid", {31'b0, out_valid}, 32'd0);
                else begin
                    if (!presenting) chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                    presenting = 1'b1;
                    chk("result", result, q[0].res);
                    chk("out_rd", {27'b0, out_instr.rd}, {27'b0, q[0].rd});
                    if (out_ready) begin
                        void'(q.pop_front());
                        presenting = 1'b0;
                    end
                end
            end else presenting = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          a1, a2, b0;
        op_e         dop [8] = '{DIV, REM, DIVU, REM, DIV, MULH, MULHU, MUL};
        logic [31:0] da  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234_5678, 32'd9,
                                 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] db  [8] = '{32'd2, 32'd2, 32'd0, 32'd0,
                                 32'hFFFF_FFFF, 32'h8000_0000, 32'd2, 32'd2};
        logic [31:0] dex [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9,
                                 32'h8000_0000, 32'h4000_0000, 32'd1, 32'hFFFF_FFFE};
        logic [31:0] ra, rb;
        op_e         rop;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_ex_rs1", ex_rs1, 32'd0);
        chk("rst_ex_rs2", ex_rs2, 32'd0);

        ready_mode = 0;
        send(ADD, 32'd5, 32'd7, 32'd12, a1);
        drain();

        send(ADD, 32'd100, 32'd23, 32'd123, a1);
        send(XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, a2);
        drain();
        chk("b2b_gap", 32'(a2 - a1), 32'd2);

        for (int i = 0; i < 8; i++) begin
            b0 = busy_cnt;
            send(dop[i], da[i], db[i], M_EN ? dex[i] : 32'h0, a1);
            drain();
            if (i == 0) chk("div_busy_cycles", 32'(busy_cnt - b0), M_EN ? 32'd33 : 32'd0);
        end

        ready_mode = 2;
        send(SUB, 32'd50, 32'd8, 32'd42, a1);
        idle();
        repeat (7) @(negedge clk);
        #2;
        chk("held_valid", {31'b0, out_valid}, 32'd1);
        chk("held_result", result, 32'd42);
        ready_mode = 0;
        drain();

        ready_mode = 2;
        send(DIV, 32'hFFFF_FFF9, 32'd2, M_EN ? 32'hFFFF_FFFD : 32'h0, a1);
        idle();
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #2;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        chk("busy_pre_flush", {31'b0, busy}, {31'b0, M_EN});
        q.delete();
        @(negedge clk);
        flush = 1'b0;
        #2;
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_idle_ready", {31'b0, in_ready}, 32'd1);
        repeat (40) @(negedge clk);
        ready_mode = 0;
        send(ADD, 32'd1, 32'd1, 32'd2, a1);
        drain();

        ready_mode = 1;
        for (int i = 0; i < 150; i++) begin
            rop = op_e'(5'($urandom_range(0, 17)));
            ra  = pick();
            rb  = pick();
            send(rop, ra, rb, model(rop, ra, rb), a1);
            if ($urandom % 4 == 0) idle();
        end
        drain();

        ready_mode = 0;
        send(MULH, 32'h1234_5678, 32'h9ABC_DEF0, model(MULH, 32'h1234_5678, 32'h9ABC_DEF0), a1);
        idle();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #2;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("midrst_result", result, 32'd0);
        chk("midrst_ex_rs1", ex_rs1, 32'd0);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (40) @(negedge clk);
        send(OR, 32'h00FF_0000, 32'h0000_00FF, 32'h00FF_00FF, a1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
